// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo read-side stages: controller state
// encodings and the widths of the state and transfer-count outputs.
package fifo_pkg;
  localparam int STATE_W  = 3;
  localparam int TX_CNT_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;
endpackage

// File: rtl/fifo_rd_ctrl_skid_buf2.sv
// Two-entry circular buffer holding words returned by the fifo until the
// downstream stream accepts them. head_data is always the oldest entry.
module skid_buf2 #(
  parameter int BITNUMBER = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 push,
  input  logic [BITNUMBER-1:0] push_data,
  input  logic                 pop,
  output logic [BITNUMBER-1:0] head_data,
  output logic [1:0]           count
);
  logic [BITNUMBER-1:0] mem_q [2];
  logic                 head_q;
  logic [1:0]           count_q;
  logic                 tail;
  logic                 do_pop;

  assign do_pop = pop && (count_q != 2'd0);
  // With one entry the free slot is the other one; with zero it is the head.
  assign tail   = head_q ^ count_q[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) mem_q[tail] <= push_data;
      if (do_pop) head_q <= ~head_q;
      count_q <= count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side consumer for fifo: issues pops under a 2-credit limit, tracks the
// fifo's read latency with an issue-bit pipe and re-streams words via skid_buf2.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-1:0] Fifo_Data_out,
  input  logic                 Fifo_empty,
  input  logic                 almost_empty,
  input  logic                 Fifo_rd_error,
  input  logic                 Fifo_wr_error,
  output logic                 Fifo_rd,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [STATE_W-1:0]   state,
  output logic                 error_out,
  output logic [TX_CNT_W-1:0]  tx_count
);
  state_t                state_q, state_d;
  logic [RD_LAT-1:0]     pipe_q;
  logic [1:0]            buf_count;
  logic [1:0]            inflight_count;
  logic                  pipe_exit;
  logic                  init_clear;
  logic                  xfer;
  logic                  credit_ok;
  logic [TX_CNT_W-1:0]   tx_count_q;

  assign pipe_exit  = pipe_q[RD_LAT-1];
  assign init_clear = (state_q == ST_INIT);
  // Stream handshake: a word moves when valid_out && ready_in at a rising
  // edge; valid_out never drops and data_out never changes until then.
  assign xfer       = valid_out && ready_in;
  assign credit_ok  = ({1'b0, buf_count} + {1'b0, inflight_count}) < 3'd2;

  always_comb begin
    inflight_count = 2'd0;
    for (int i = 0; i < RD_LAT; i++) inflight_count = inflight_count + {1'b0, pipe_q[i]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Fifo_rd = 1'b0;
    if (state_q != ST_RESET && (Fifo_rd_error || Fifo_wr_error)) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_RESET:  state_d = ST_INIT;
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE:   if (!Fifo_empty) state_d = ST_ACTIVE;
        ST_ACTIVE: if (Fifo_empty && inflight_count == 2'd0 && buf_count == 2'd0)
                     state_d = ST_IDLE;
        ST_ERROR:  state_d = ST_ERROR;
        default:   state_d = ST_RESET;
      endcase
    end
    // pipe_q[0] is the issue bit of the previous cycle; the fifo's flags have
    // not yet seen that pop, so almost_empty then means it is already drained.
    if (state_q == ST_ACTIVE && !Fifo_empty && !(almost_empty && pipe_q[0]) && credit_ok)
      Fifo_rd = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q <= '0;
    end else if (init_clear) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= Fifo_rd;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          tx_count_q <= '0;
    else if (init_clear) tx_count_q <= '0;
    else if (xfer)       tx_count_q <= tx_count_q + 1'b1;
  end

  skid_buf2 #(.BITNUMBER(BITNUMBER)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (init_clear),
    .push      (pipe_exit && !init_clear),
    .push_data (Fifo_Data_out),
    .pop       (xfer),
    .head_data (data_out),
    .count     (buf_count)
  );

  assign valid_out = (buf_count != 2'd0);
  assign state     = state_q;
  assign error_out = (state_q == ST_ERROR);
  assign tx_count  = tx_count_q;

  // The credit limit must keep a returning word from ever meeting a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (pipe_exit && !init_clear) |-> (buf_count != 2'd2));
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: two instances (RD_LAT=1 and RD_LAT=2) fed by
// behavioural fifos whose flags lag the pops by one cycle.
module tb_fifo_rd_ctrl;
  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;

  // channel 0: RD_LAT=1
  logic        rst0, fempty0, fae0, rd_err0, wr_err0, frd0, vout0, rdy0, err0;
  logic [7:0]  fdata0, dout0;
  logic [2:0]  st0;
  logic [15:0] txc0;
  // channel 1: RD_LAT=2
  logic        rst1, fempty1, fae1, rd_err1, wr_err1, frd1, vout1, rdy1, err1;
  logic [7:0]  fdata1, dout1, s1a;
  logic [2:0]  st1;
  logic [15:0] txc1;

  logic [7:0] fq0[$], fq1[$];
  logic [7:0] exp_q[$], exp_q_lat2[$];
  int shown0 = 0, shown1 = 0;
  int rd_cnt0 = 0, rd_cnt1 = 0, empty_pops0 = 0, empty_pops1 = 0;
  int n_xfer0 = 0, n_xfer1 = 0;

  fifo_rd_ctrl #(.BITNUMBER(8), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(rst0), .Fifo_Data_out(fdata0), .Fifo_empty(fempty0),
    .almost_empty(fae0), .Fifo_rd_error(rd_err0), .Fifo_wr_error(wr_err0),
    .Fifo_rd(frd0), .data_out(dout0), .valid_out(vout0), .ready_in(rdy0),
    .state(st0), .error_out(err0), .tx_count(txc0));

  fifo_rd_ctrl #(.BITNUMBER(8), .RD_LAT(2)) u_dut_lat2 (
    .clk(clk), .reset(rst1), .Fifo_Data_out(fdata1), .Fifo_empty(fempty1),
    .almost_empty(fae1), .Fifo_rd_error(rd_err1), .Fifo_wr_error(wr_err1),
    .Fifo_rd(frd1), .data_out(dout1), .valid_out(vout1), .ready_in(rdy1),
    .state(st1), .error_out(err1), .tx_count(txc1));

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // behavioural fifos: flags reflect the occupancy before the latest edge
  assign fempty0 = (shown0 == 0);
  assign fae0    = (shown0 == 1);
  assign fempty1 = (shown1 == 0);
  assign fae1    = (shown1 == 1);

  always @(posedge clk) begin
    shown0 <= fq0.size();
    if (frd0) begin
      rd_cnt0 <= rd_cnt0 + 1;
      if (fq0.size() == 0) empty_pops0 <= empty_pops0 + 1;
      else                 fdata0 <= fq0.pop_front();
    end
  end

  always @(posedge clk) begin
    shown1 <= fq1.size();
    fdata1 <= s1a;
    if (frd1) begin
      rd_cnt1 <= rd_cnt1 + 1;
      if (fq1.size() == 0) empty_pops1 <= empty_pops1 + 1;
      else                 s1a <= fq1.pop_front();
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard monitors: sample just before the edge that completes a transfer
  always @(negedge clk) begin
    if (rst0 && vout0 && rdy0) begin
      check("ch0_sb_has_word", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("ch0_data", dout0, exp_q.pop_front());
      n_xfer0 <= n_xfer0 + 1;
    end
  end

  always @(negedge clk) begin
    if (rst1 && vout1 && rdy1) begin
      check("lat2_sb_has_word", exp_q_lat2.size() != 0, 1);
      if (exp_q_lat2.size() != 0) check("lat2_data", dout1, exp_q_lat2.pop_front());
      n_xfer1 <= n_xfer1 + 1;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load0(input logic [7:0] w);
    fq0.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic load1(input logic [7:0] w);
    fq1.push_back(w);
    exp_q_lat2.push_back(w);
  endtask

  initial begin
    int r, t, remaining;
    rst0 = 1'b0; rst1 = 1'b0;
    rd_err0 = 1'b0; wr_err0 = 1'b0; rd_err1 = 1'b0; wr_err1 = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (3) step();

    // reset values
    check("rst_fifo_rd", frd0, 0);
    check("rst_valid", vout0, 0);
    check("rst_data", dout0, 0);
    check("rst_state", st0, 0);
    check("rst_error", err0, 0);
    check("rst_tx_count", txc0, 0);
    check("rst_lat2_state", st1, 0);

    // release with empty fifo: 0 -> 1 -> 2, then idle
    rst0 = 1'b1;
    step(); check("seq_init", st0, 1);
    step(); check("seq_idle", st0, 2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_state", st0, 2);
      check("idle_fifo_rd", frd0, 0);
      check("idle_valid", vout0, 0);
    end
    check("idle_no_pops", rd_cnt0, 0);

    // three preloaded words
    r = rd_cnt0; t = n_xfer0;
    load0(8'h11); load0(8'h22); load0(8'h33);
    for (int i = 0; i < 30 && n_xfer0 != t + 3; i++) step();
    check("three_xfers", n_xfer0 - t, 3);
    repeat (3) step();
    check("three_pops", rd_cnt0 - r, 3);
    check("three_tx_count", txc0, 3);
    check("three_back_idle", st0, 2);
    check("three_sb_empty", exp_q.size(), 0);

    // backpressure
    r = rd_cnt0; t = n_xfer0;
    rdy0 = 1'b0;
    load0(8'h44); load0(8'h55); load0(8'h66); load0(8'h77);
    repeat (5) step();
    check("bp_hold_data_mid", dout0, 8'h44);
    repeat (5) step();
    check("bp_at_most_2_pops", (rd_cnt0 - r) <= 2, 1);
    check("bp_valid", vout0, 1);
    check("bp_hold_data", dout0, 8'h44);
    rdy0 = 1'b1;
    for (int i = 0; i < 40 && n_xfer0 != t + 4; i++) step();
    check("bp_all_xfers", n_xfer0 - t, 4);
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_tx_count", txc0, 7);

    // single word seen through almost_empty
    repeat (3) step();
    r = rd_cnt0; t = n_xfer0;
    load0($urandom_range(0, 255));
    for (int i = 0; i < 20 && n_xfer0 != t + 1; i++) step();
    repeat (3) step();
    check("single_xfer", n_xfer0 - t, 1);
    check("single_one_pop", rd_cnt0 - r, 1);
    check("single_no_empty_pop", empty_pops0, 0);
    check("single_idle", st0, 2);

    // write-error while one word is buffered
    rdy0 = 1'b0;
    load0(8'h99);
    for (int i = 0; i < 20 && !vout0; i++) step();
    check("err_word_buffered", vout0, 1);
    load0(8'hAA); load0(8'hBB);
    wr_err0 = 1'b1;
    step();
    wr_err0 = 1'b0;
    check("err_state", st0, 4);
    check("err_flag", err0, 1);
    check("err_no_rd", frd0, 0);
    r = rd_cnt0; t = n_xfer0;
    repeat (5) step();
    check("err_sticky_state", st0, 4);
    check("err_no_more_pops", rd_cnt0, r);
    check("err_hold_data", dout0, 8'h99);
    rdy0 = 1'b1;
    for (int i = 0; i < 10 && n_xfer0 != t + 1; i++) step();
    repeat (3) step();
    check("err_drain_xfer", n_xfer0 - t, 1);
    check("err_still_error", err0, 1);
    check("err_still_no_pops", rd_cnt0, r);
    rst0 = 1'b0;
    #1;
    check("err_reset_state", st0, 0);
    check("err_reset_flag", err0, 0);
    check("err_reset_tx", txc0, 0);
    while (exp_q.size() > fq0.size()) void'(exp_q.pop_front());
    step();
    rst0 = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    repeat (3) step();
    check("post_err_sb_empty", exp_q.size(), 0);
    check("post_err_tx_count", txc0, 2);
    check("post_err_idle", st0, 2);
    check("ch0_no_empty_pop", empty_pops0, 0);

    // RD_LAT=2 with asynchronous reset mid-stream
    rst1 = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 8; i++) load1($urandom_range(0, 255));
    for (int i = 0; i < 40 && txc1 < 16'd2; i++) step();
    check("lat2_started", txc1 >= 16'd2, 1);
    rst1 = 1'b0;
    #1;
    check("lat2_rst_valid", vout1, 0);
    check("lat2_rst_fifo_rd", frd1, 0);
    check("lat2_rst_state", st1, 0);
    check("lat2_rst_tx", txc1, 0);
    check("lat2_rst_data", dout1, 0);
    check("lat2_rst_error", err1, 0);
    while (exp_q_lat2.size() > fq1.size()) void'(exp_q_lat2.pop_front());
    repeat (2) step();
    remaining = fq1.size();
    rst1 = 1'b1;
    for (int i = 0; i < 100 && exp_q_lat2.size() != 0; i++) step();
    repeat (4) step();
    check("lat2_sb_empty", exp_q_lat2.size(), 0);
    check("lat2_tx_restart", txc1, remaining);
    check("lat2_idle", st1, 2);
    check("lat2_no_empty_pop", empty_pops1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
